// File: rtl/pipeline_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_hazard_ctrl_if
// Brief    : Hazard-control bus between pipeline stage datapath and controller.
// Revision : 1.0
// ============================================================================
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       i_id_rs1;
    logic [4:0]       i_id_rs2;
    logic             i_id_use_rs1;
    logic             i_id_use_rs2;
    logic [4:0]       i_ex_rs1;
    logic [4:0]       i_ex_rs2;
    logic [4:0]       i_ex_rd;
    logic             i_ex_rd_wren;
    logic             i_ex_is_load;
    logic             i_ex_redirect;
    logic [4:0]       i_mem_rd;
    logic             i_mem_rd_wren;
    logic [4:0]       i_wb_rd;
    logic             i_wb_rd_wren;
    logic             i_lsu_req;
    logic             i_lsu_ack;
    logic             o_pc_en;
    logic             o_if_id_en;
    logic             o_if_id_flush;
    logic             o_id_ex_en;
    logic             o_id_ex_flush;
    logic             o_ex_mem_en;
    logic             o_mem_wb_bubble;
    logic [1:0]       o_fwd_a_sel;
    logic [1:0]       o_fwd_b_sel;
    logic             o_mem_timeout;
    logic [CNT_W-1:0] o_stall_cnt;
    logic [CNT_W-1:0] o_flush_cnt;

    modport master (
        output i_id_rs1, i_id_rs2, i_id_use_rs1, i_id_use_rs2,
        output i_ex_rs1, i_ex_rs2, i_ex_rd, i_ex_rd_wren, i_ex_is_load, i_ex_redirect,
        output i_mem_rd, i_mem_rd_wren, i_wb_rd, i_wb_rd_wren, i_lsu_req, i_lsu_ack,
        input  o_pc_en, o_if_id_en, o_if_id_flush, o_id_ex_en, o_id_ex_flush,
        input  o_ex_mem_en, o_mem_wb_bubble, o_fwd_a_sel, o_fwd_b_sel,
        input  o_mem_timeout, o_stall_cnt, o_flush_cnt
    );

    modport slave (
        input  i_id_rs1, i_id_rs2, i_id_use_rs1, i_id_use_rs2,
        input  i_ex_rs1, i_ex_rs2, i_ex_rd, i_ex_rd_wren, i_ex_is_load, i_ex_redirect,
        input  i_mem_rd, i_mem_rd_wren, i_wb_rd, i_wb_rd_wren, i_lsu_req, i_lsu_ack,
        output o_pc_en, o_if_id_en, o_if_id_flush, o_id_ex_en, o_id_ex_flush,
        output o_ex_mem_en, o_mem_wb_bubble, o_fwd_a_sel, o_fwd_b_sel,
        output o_mem_timeout, o_stall_cnt, o_flush_cnt
    );
endinterface
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_hazard_ctrl
// Brief    : 5-stage pipeline stall/flush/forward control with MEM wait timeout.
// Revision : 1.0
// ============================================================================
module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  wire logic             i_clk,
    input  wire logic             i_reset,
    pipeline_hazard_ctrl_if.slave bus
);
    localparam int WCNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WCNT_W-1:0] C_WCNT_LAST = WCNT_W'(MEM_TIMEOUT - 1);
    localparam logic [WCNT_W-1:0] C_WCNT_ONE  = WCNT_W'(1);
    localparam logic [CNT_W-1:0]  C_CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  C_CNT_MAX   = {CNT_W{1'b1}};

    typedef enum logic [0:0] {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [WCNT_W-1:0]  wcnt_q, wcnt_d;
    logic               timeout_q, timeout_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;

    logic       w_at_limit;
    logic       w_mem_stall;
    logic       w_load_use;
    logic       w_pc_en;
    logic       w_if_id_en;
    logic       w_if_id_flush;
    logic       w_id_ex_en;
    logic       w_id_ex_flush;
    logic       w_ex_mem_en;
    logic       w_mem_wb_bubble;
    logic [1:0] w_fwd_a_sel;
    logic [1:0] w_fwd_b_sel;

    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic [4:0] mem_rd, input logic mem_wren,
        input logic [4:0] wb_rd,  input logic wb_wren
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (mem_wren && (mem_rd != 5'd0) && (mem_rd == rs)) begin
            sel = 2'b01;
        end else if (wb_wren && (wb_rd != 5'd0) && (wb_rd == rs)) begin
            sel = 2'b10;
        end
        return sel;
    endfunction

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q     <= ST_RUN;
            wcnt_q      <= '0;
            timeout_q   <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            timeout_q   <= timeout_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        wcnt_d          = wcnt_q;
        timeout_d       = 1'b0;
        stall_cnt_d     = stall_cnt_q;
        flush_cnt_d     = flush_cnt_q;
        w_pc_en         = 1'b1;
        w_if_id_en      = 1'b1;
        w_if_id_flush   = 1'b0;
        w_id_ex_en      = 1'b1;
        w_id_ex_flush   = 1'b0;
        w_ex_mem_en     = 1'b1;
        w_mem_wb_bubble = 1'b0;
        w_fwd_a_sel     = 2'b00;
        w_fwd_b_sel     = 2'b00;

        // On the last allowed wait cycle the stall is dropped so the access is forced out.
        w_at_limit  = (state_q == ST_MEM_WAIT) && (wcnt_q == C_WCNT_LAST);
        w_mem_stall = bus.i_lsu_req && !bus.i_lsu_ack && !w_at_limit;
        w_load_use  = bus.i_ex_is_load && bus.i_ex_rd_wren && (bus.i_ex_rd != 5'd0) &&
                      ((bus.i_id_use_rs1 && (bus.i_id_rs1 == bus.i_ex_rd)) ||
                       (bus.i_id_use_rs2 && (bus.i_id_rs2 == bus.i_ex_rd)));

        if (state_q == ST_RUN) begin
            if (bus.i_lsu_req && !bus.i_lsu_ack) begin
                state_d = ST_MEM_WAIT;
                wcnt_d  = '0;
            end
        end else begin
            if (bus.i_lsu_ack) begin
                state_d = ST_RUN;
            end else if (w_at_limit) begin
                state_d   = ST_RUN;
                timeout_d = 1'b1;
            end else begin
                wcnt_d = wcnt_q + C_WCNT_ONE;
            end
        end

        if (w_mem_stall) begin
            w_pc_en         = 1'b0;
            w_if_id_en      = 1'b0;
            w_id_ex_en      = 1'b0;
            w_ex_mem_en     = 1'b0;
            w_mem_wb_bubble = 1'b1;
        end else if (bus.i_ex_redirect) begin
            w_if_id_flush = 1'b1;
            w_id_ex_flush = 1'b1;
            if (flush_cnt_q != C_CNT_MAX) begin
                flush_cnt_d = flush_cnt_q + C_CNT_ONE;
            end
        end else if (w_load_use) begin
            w_pc_en       = 1'b0;
            w_if_id_en    = 1'b0;
            w_id_ex_flush = 1'b1;
        end

        if (!w_pc_en && (stall_cnt_q != C_CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + C_CNT_ONE;
        end

        w_fwd_a_sel = fwd_sel(bus.i_ex_rs1, bus.i_mem_rd, bus.i_mem_rd_wren,
                              bus.i_wb_rd, bus.i_wb_rd_wren);
        w_fwd_b_sel = fwd_sel(bus.i_ex_rs2, bus.i_mem_rd, bus.i_mem_rd_wren,
                              bus.i_wb_rd, bus.i_wb_rd_wren);

        // Reset overrides the decode so every stage holds a NOP while reset is active.
        if (i_reset) begin
            w_pc_en         = 1'b0;
            w_if_id_en      = 1'b0;
            w_id_ex_en      = 1'b0;
            w_ex_mem_en     = 1'b0;
            w_if_id_flush   = 1'b1;
            w_id_ex_flush   = 1'b1;
            w_mem_wb_bubble = 1'b1;
            w_fwd_a_sel     = 2'b00;
            w_fwd_b_sel     = 2'b00;
        end
    end

    assign bus.o_pc_en         = w_pc_en;
    assign bus.o_if_id_en      = w_if_id_en;
    assign bus.o_if_id_flush   = w_if_id_flush;
    assign bus.o_id_ex_en      = w_id_ex_en;
    assign bus.o_id_ex_flush   = w_id_ex_flush;
    assign bus.o_ex_mem_en     = w_ex_mem_en;
    assign bus.o_mem_wb_bubble = w_mem_wb_bubble;
    assign bus.o_fwd_a_sel     = w_fwd_a_sel;
    assign bus.o_fwd_b_sel     = w_fwd_b_sel;
    assign bus.o_mem_timeout   = timeout_q;
    assign bus.o_stall_cnt     = stall_cnt_q;
    assign bus.o_flush_cnt     = flush_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_hazard_ctrl
// Brief    : Directed + randomized bench for pipeline_hazard_ctrl with reference model.
// Revision : 1.0
// ============================================================================
module tb_pipeline_hazard_ctrl;
    localparam int TO      = 16;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    // Reference model state: waiting flag, cycles spent waiting, counters, pending pulse.
    bit m_wait;
    int m_wcnt;
    int m_stall;
    int m_flush;
    bit m_pulse;

    pipeline_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CNT_W)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            if (n_err <= 40)
                $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    function automatic int ref_fwd(input int rs);
        if (bus.i_mem_rd_wren && bus.i_mem_rd != 0 && bus.i_mem_rd == rs) return 1;
        if (bus.i_wb_rd_wren && bus.i_wb_rd != 0 && bus.i_wb_rd == rs) return 2;
        return 0;
    endfunction

    task automatic check_and_advance();
        bit tnow, ms, lu, hit1, hit2;
        bit e_pc, e_ifid, e_ifid_f, e_idex, e_idex_f, e_exmem, e_bub;
        int e_fa, e_fb;
        tnow = m_wait && (m_wcnt == TO - 1);
        ms   = bus.i_lsu_req && !bus.i_lsu_ack && !tnow;
        hit1 = bus.i_id_use_rs1 && (bus.i_id_rs1 == bus.i_ex_rd);
        hit2 = bus.i_id_use_rs2 && (bus.i_id_rs2 == bus.i_ex_rd);
        lu   = bus.i_ex_is_load && bus.i_ex_rd_wren && (bus.i_ex_rd != 0) && (hit1 || hit2);
        {e_pc, e_ifid, e_idex, e_exmem} = 4'b1111;
        {e_ifid_f, e_idex_f, e_bub}     = 3'b000;
        e_fa = ref_fwd(int'(bus.i_ex_rs1));
        e_fb = ref_fwd(int'(bus.i_ex_rs2));
        if (rst) begin
            {e_pc, e_ifid, e_idex, e_exmem} = 4'b0000;
            {e_ifid_f, e_idex_f, e_bub}     = 3'b111;
            e_fa = 0;
            e_fb = 0;
        end else if (ms) begin
            {e_pc, e_ifid, e_idex, e_exmem} = 4'b0000;
            e_bub = 1'b1;
        end else if (bus.i_ex_redirect) begin
            {e_ifid_f, e_idex_f} = 2'b11;
        end else if (lu) begin
            {e_pc, e_ifid} = 2'b00;
            e_idex_f = 1'b1;
        end

        @(negedge clk);
        chk("pc_en",      32'(bus.o_pc_en),         32'(e_pc));
        chk("if_id_en",   32'(bus.o_if_id_en),      32'(e_ifid));
        chk("if_id_fl",   32'(bus.o_if_id_flush),   32'(e_ifid_f));
        chk("id_ex_en",   32'(bus.o_id_ex_en),      32'(e_idex));
        chk("id_ex_fl",   32'(bus.o_id_ex_flush),   32'(e_idex_f));
        chk("ex_mem_en",  32'(bus.o_ex_mem_en),     32'(e_exmem));
        chk("mwb_bubble", 32'(bus.o_mem_wb_bubble), 32'(e_bub));
        chk("fwd_a",      32'(bus.o_fwd_a_sel),     32'(e_fa));
        chk("fwd_b",      32'(bus.o_fwd_b_sel),     32'(e_fb));
        chk("timeout",    32'(bus.o_mem_timeout),   rst ? 32'd0 : 32'(m_pulse));
        chk("stall_cnt",  32'(bus.o_stall_cnt),     rst ? 32'd0 : 32'(m_stall));
        chk("flush_cnt",  32'(bus.o_flush_cnt),     rst ? 32'd0 : 32'(m_flush));

        if (rst) begin
            m_wait = 0; m_wcnt = 0; m_stall = 0; m_flush = 0; m_pulse = 0;
        end else begin
            m_pulse = m_wait && tnow && !bus.i_lsu_ack;
            if (!m_wait) begin
                if (bus.i_lsu_req && !bus.i_lsu_ack) begin
                    m_wait = 1;
                    m_wcnt = 0;
                end
            end else if (bus.i_lsu_ack || tnow) begin
                m_wait = 0;
            end else begin
                m_wcnt++;
            end
            if (!e_pc && m_stall < CNT_MAX) m_stall++;
            if (bus.i_ex_redirect && !ms && m_flush < CNT_MAX) m_flush++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.i_id_rs1 = 0; bus.i_id_rs2 = 0; bus.i_id_use_rs1 = 0; bus.i_id_use_rs2 = 0;
        bus.i_ex_rs1 = 0; bus.i_ex_rs2 = 0; bus.i_ex_rd = 0; bus.i_ex_rd_wren = 0;
        bus.i_ex_is_load = 0; bus.i_ex_redirect = 0;
        bus.i_mem_rd = 0; bus.i_mem_rd_wren = 0; bus.i_wb_rd = 0; bus.i_wb_rd_wren = 0;
        bus.i_lsu_req = 0; bus.i_lsu_ack = 0;
    endtask

    task automatic randomize_inputs();
        bus.i_id_rs1      = 5'($urandom_range(0, 3));
        bus.i_id_rs2      = 5'($urandom_range(0, 3));
        bus.i_id_use_rs1  = 1'($urandom_range(0, 1));
        bus.i_id_use_rs2  = 1'($urandom_range(0, 1));
        bus.i_ex_rs1      = 5'($urandom_range(0, 3));
        bus.i_ex_rs2      = 5'($urandom_range(0, 3));
        bus.i_ex_rd       = 5'($urandom_range(0, 3));
        bus.i_ex_rd_wren  = ($urandom_range(0, 3) != 0);
        bus.i_ex_is_load  = ($urandom_range(0, 2) == 0);
        bus.i_ex_redirect = ($urandom_range(0, 6) == 0);
        bus.i_mem_rd      = 5'($urandom_range(0, 3));
        bus.i_mem_rd_wren = 1'($urandom_range(0, 1));
        bus.i_wb_rd       = 5'($urandom_range(0, 3));
        bus.i_wb_rd_wren  = 1'($urandom_range(0, 1));
        bus.i_lsu_req     = ($urandom_range(0, 2) == 0);
        bus.i_lsu_ack     = ($urandom_range(0, 9) == 0);
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        m_wait = 0; m_wcnt = 0; m_stall = 0; m_flush = 0; m_pulse = 0;
        rst = 1'b1;
        idle();
        #1;
        repeat (2) check_and_advance();
        rst = 1'b0;
        check_and_advance();

        // Load-use: lw x5 in EX, add x6,x5,x1 in ID; then add in EX with load in WB.
        idle();
        bus.i_ex_is_load = 1; bus.i_ex_rd = 5; bus.i_ex_rd_wren = 1;
        bus.i_id_use_rs1 = 1; bus.i_id_rs1 = 5; bus.i_id_use_rs2 = 1; bus.i_id_rs2 = 1;
        check_and_advance();
        idle();
        bus.i_ex_rs1 = 5; bus.i_ex_rs2 = 1; bus.i_wb_rd = 5; bus.i_wb_rd_wren = 1;
        check_and_advance();

        // Non-writing load / x0 load: no stall; MEM beats WB forwarding on x7.
        idle();
        bus.i_ex_is_load = 1; bus.i_ex_rd = 3; bus.i_ex_rd_wren = 0;
        bus.i_id_use_rs1 = 1; bus.i_id_rs1 = 3;
        check_and_advance();
        bus.i_ex_rd = 0; bus.i_ex_rd_wren = 1; bus.i_id_rs1 = 0;
        bus.i_mem_rd = 7; bus.i_mem_rd_wren = 1; bus.i_wb_rd = 7; bus.i_wb_rd_wren = 1;
        bus.i_ex_rs2 = 7;
        check_and_advance();

        // Redirect overriding a load-use hazard.
        idle();
        bus.i_ex_is_load = 1; bus.i_ex_rd = 5; bus.i_ex_rd_wren = 1;
        bus.i_id_use_rs1 = 1; bus.i_id_rs1 = 5; bus.i_ex_redirect = 1;
        check_and_advance();

        // Memory access acked after 3 cycles with a redirect waiting behind it.
        idle();
        bus.i_lsu_req = 1; bus.i_ex_redirect = 1;
        repeat (3) check_and_advance();
        bus.i_lsu_ack = 1;
        check_and_advance();
        idle();
        check_and_advance();

        // Memory never acks: forced release and timeout pulse.
        bus.i_lsu_req = 1;
        repeat (TO + 1) check_and_advance();
        idle();
        repeat (2) check_and_advance();

        // Reset in the middle of a wait.
        bus.i_lsu_req = 1;
        repeat (5) check_and_advance();
        rst = 1'b1;
        check_and_advance();
        rst = 1'b0;
        idle();
        check_and_advance();

        for (int i = 0; i < 3000; i++) begin
            randomize_inputs();
            if (i % 40 < 25 && i % 400 > 200) begin
                bus.i_lsu_req = 1;
                bus.i_lsu_ack = 0;
            end
            rst = ($urandom_range(0, 299) == 0);
            check_and_advance();
        end
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
